// File: rtl/washer_seq_ctrl.sv
// washer_seq_ctrl
// ---------------
// Program sequencer for the washing-machine datapath. It steps through
// FILL -> agitation loop -> DRAIN (-> FILL for rinse) -> SPIN. Timed steps
// count a 1 Hz tick strobe. Level sensors close FILL and DRAIN early; if a
// sensor never arrives, the step times out, latches a fault and returns to IDLE.
//
// Optional feature macro: WASHER_PAUSE_EN
//   Defined   : adds input i_pause. While i_pause is high in a running program,
//               the state, timer and cycle count freeze, ticks are ignored and
//               every actuator is off.
//   Undefined : no pause port.
//
// Ports
//   clk             system clock
//   rst             asynchronous active-high reset
//   i_tick          one-cycle 1 Hz strobe
//   i_start         one-cycle start request (accepted only in IDLE)
//   i_prog[1:0]     00 wash+rinse+spin, 01 rinse+spin, 10 spin only, 11 invalid
//   i_estop         emergency stop, level
//   i_water_full    level sensor high
//   i_water_empty   level sensor low
//   i_pause         (WASHER_PAUSE_EN only) pause, level
//   o_inlet         water inlet valve
//   o_drain         drain valve
//   o_motor_fwd     motor forward enable
//   o_motor_rev     motor reverse enable
//   o_spin          spin motor enable
//   o_busy          program running
//   o_done          one-cycle completion pulse
//   o_alarm         latched fault flag (fill or drain timeout)
//   o_phase[2:0]    current state code
//   o_remain[6:0]   ticks left in the current timed step

module washer_seq_ctrl #(
  parameter int unsigned FILL_S    = 10,
  parameter int unsigned AGIT_S    = 60,
  parameter int unsigned REST_S    = 5,
  parameter int unsigned DRAIN_S   = 20,
  parameter int unsigned SPIN_S    = 30,
  parameter int unsigned WASH_CYC  = 7,
  parameter int unsigned RINSE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [1:0] i_prog,
  input  logic       i_estop,
  input  logic       i_water_full,
  input  logic       i_water_empty,
`ifdef WASHER_PAUSE_EN
  input  logic       i_pause,
`endif
  output logic       o_inlet,
  output logic       o_drain,
  output logic       o_motor_fwd,
  output logic       o_motor_rev,
  output logic       o_spin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_alarm,
  output logic [2:0] o_phase,
  output logic [6:0] o_remain
);

  // Enumerator values are the externally visible phase codes.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StAgitF = 3'd2,
    StRestA = 3'd3,
    StAgitR = 3'd4,
    StRestB = 3'd5,
    StDrain = 3'd6,
    StSpin  = 3'd7
  } state_e;

  typedef enum logic {
    StageWash  = 1'b0,
    StageRinse = 1'b1
  } stage_e;

  // Step length loaded into the timer on entry to each state.
  function automatic logic [6:0] step_len(input state_e s);
    logic [6:0] len;
    len = 7'd0;
    case (s)
      StFill:           len = 7'(FILL_S);
      StAgitF, StAgitR: len = 7'(AGIT_S);
      StRestA, StRestB: len = 7'(REST_S);
      StDrain:          len = 7'(DRAIN_S);
      StSpin:           len = 7'(SPIN_S);
      default:          len = 7'd0;
    endcase
    return len;
  endfunction

  // Registered state
  state_e     r_state;
  stage_e     r_stage;
  logic [6:0] r_remain;
  logic [3:0] r_cyc;
  logic       r_alarm;
  logic       r_done;
  logic       r_busy;
  logic       r_inlet;
  logic       r_drain;
  logic       r_fwd;
  logic       r_rev;
  logic       r_spin;

  // Next-state values
  state_e     w_state_d;
  stage_e     w_stage_d;
  logic [6:0] w_remain_d;
  logic [3:0] w_cyc_d;
  logic       w_alarm_d;
  logic       w_done_d;
  logic       w_last_tick;
  logic       w_hold;
  logic       w_pause;

`ifdef WASHER_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  // A tick that arrives while the timer shows 1 ends the step: a normal
  // exit for fixed-length steps, a timeout for FILL and DRAIN.
  assign w_last_tick = i_tick && (r_remain == 7'd1);

  // Pause freezes a running program only. In IDLE there is nothing to hold.
  assign w_hold = w_pause && (r_state != StIdle);

  always_comb begin
    w_state_d  = r_state;
    w_stage_d  = r_stage;
    w_remain_d = r_remain;
    w_cyc_d    = r_cyc;
    w_alarm_d  = r_alarm;
    w_done_d   = 1'b0;

    if (i_estop) begin
      // Abort without touching alarm and without a done pulse.
      w_state_d  = StIdle;
      w_stage_d  = StageWash;
      w_cyc_d    = 4'd0;
      w_remain_d = 7'd0;
    end else if (!w_hold) begin
      unique case (r_state)
        StIdle: begin
          if (i_start && (i_prog != 2'b11)) begin
            w_alarm_d = 1'b0;
            unique case (i_prog)
              2'b00: begin
                w_stage_d = StageWash;
                w_state_d = StFill;
              end
              2'b01: begin
                w_stage_d = StageRinse;
                w_state_d = StFill;
              end
              default: begin
                // Spin-only: entering DRAIN as a rinse routes its exit to SPIN.
                w_stage_d = StageRinse;
                w_state_d = StDrain;
              end
            endcase
          end
        end

        StFill: begin
          // Sensor exit outranks a simultaneous final tick.
          if (i_water_full) begin
            w_cyc_d   = (r_stage == StageWash) ? 4'(WASH_CYC) : 4'(RINSE_CYC);
            w_state_d = StAgitF;
          end else if (w_last_tick) begin
            w_alarm_d = 1'b1;
            w_state_d = StIdle;
          end
        end

        StAgitF: if (w_last_tick) w_state_d = StRestA;
        StRestA: if (w_last_tick) w_state_d = StAgitR;
        StAgitR: if (w_last_tick) w_state_d = StRestB;

        StRestB: begin
          if (w_last_tick) begin
            w_cyc_d   = r_cyc - 4'd1;
            w_state_d = (w_cyc_d == 4'd0) ? StDrain : StAgitF;
          end
        end

        StDrain: begin
          if (i_water_empty) begin
            if (r_stage == StageWash) begin
              w_stage_d = StageRinse;
              w_state_d = StFill;
            end else begin
              w_state_d = StSpin;
            end
          end else if (w_last_tick) begin
            w_alarm_d = 1'b1;
            w_state_d = StIdle;
          end
        end

        StSpin: begin
          if (w_last_tick) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end
        end

        default: w_state_d = StIdle;
      endcase

      // Timer: reload on every state change, otherwise count ticks down.
      if (w_state_d != r_state) begin
        w_remain_d = step_len(w_state_d);
      end else if (i_tick && (r_state != StIdle)) begin
        w_remain_d = r_remain - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_stage  <= StageWash;
      r_remain <= 7'd0;
      r_cyc    <= 4'd0;
      r_alarm  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_inlet  <= 1'b0;
      r_drain  <= 1'b0;
      r_fwd    <= 1'b0;
      r_rev    <= 1'b0;
      r_spin   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_stage  <= w_stage_d;
      r_remain <= w_remain_d;
      r_cyc    <= w_cyc_d;
      r_alarm  <= w_alarm_d;
      r_done   <= w_done_d;
      r_busy   <= (w_state_d != StIdle);
      // Actuators are decoded from the next state so they line up with
      // o_phase. They are forced off while a pause holds the program.
      r_inlet  <= !w_hold && (w_state_d == StFill);
      r_drain  <= !w_hold && ((w_state_d == StDrain) || (w_state_d == StSpin));
      r_fwd    <= !w_hold && (w_state_d == StAgitF);
      r_rev    <= !w_hold && (w_state_d == StAgitR);
      r_spin   <= !w_hold && (w_state_d == StSpin);
    end
  end

  assign o_inlet     = r_inlet;
  assign o_drain     = r_drain;
  assign o_motor_fwd = r_fwd;
  assign o_motor_rev = r_rev;
  assign o_spin      = r_spin;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_alarm     = r_alarm;
  assign o_phase     = r_state;
  assign o_remain    = r_remain;

endmodule

// File: tb/tb_washer_seq_ctrl.sv
// Testbench for washer_seq_ctrl. Each program is expanded into a list of
// (phase, length, sensor-closed) steps built from the program rules. The bench
// then walks that list using randomized tick spacing and sensor arrival times.

module tb_washer_seq_ctrl;

  localparam int unsigned FILL_S    = 4;
  localparam int unsigned AGIT_S    = 3;
  localparam int unsigned REST_S    = 2;
  localparam int unsigned DRAIN_S   = 4;
  localparam int unsigned SPIN_S    = 5;
  localparam int unsigned WASH_CYC  = 2;
  localparam int unsigned RINSE_CYC = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick, i_start, i_estop, i_water_full, i_water_empty, i_pause;
  logic [1:0] i_prog;
  logic       o_inlet, o_drain, o_motor_fwd, o_motor_rev, o_spin;
  logic       o_busy, o_done, o_alarm;
  logic [2:0] o_phase;
  logic [6:0] o_remain;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    int ph;
    int dur;
    bit sens;
  } step_t;
  step_t plan[$];

  always #5 clk = ~clk;

  washer_seq_ctrl #(
    .FILL_S   (FILL_S),
    .AGIT_S   (AGIT_S),
    .REST_S   (REST_S),
    .DRAIN_S  (DRAIN_S),
    .SPIN_S   (SPIN_S),
    .WASH_CYC (WASH_CYC),
    .RINSE_CYC(RINSE_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (i_tick),
    .i_start      (i_start),
    .i_prog       (i_prog),
    .i_estop      (i_estop),
    .i_water_full (i_water_full),
    .i_water_empty(i_water_empty),
`ifdef WASHER_PAUSE_EN
    .i_pause      (i_pause),
`endif
    .o_inlet      (o_inlet),
    .o_drain      (o_drain),
    .o_motor_fwd  (o_motor_fwd),
    .o_motor_rev  (o_motor_rev),
    .o_spin       (o_spin),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_alarm      (o_alarm),
    .o_phase      (o_phase),
    .o_remain     (o_remain)
  );

  // Expected {inlet, drain, fwd, rev, spin} for a phase code.
  function automatic logic [4:0] exp_act(input int ph);
    logic [4:0] a;
    case (ph)
      1:       a = 5'b10000;
      2:       a = 5'b00100;
      4:       a = 5'b00010;
      6:       a = 5'b01000;
      7:       a = 5'b01001;
      default: a = 5'b00000;
    endcase
    return a;
  endfunction

  function automatic logic [4:0] act();
    return {o_inlet, o_drain, o_motor_fwd, o_motor_rev, o_spin};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random idle spacing, then one tick cycle.
  task automatic do_tick();
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) step();
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
  endtask

  task automatic add_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      plan.push_back('{2, AGIT_S, 1'b0});
      plan.push_back('{3, REST_S, 1'b0});
      plan.push_back('{4, AGIT_S, 1'b0});
      plan.push_back('{5, REST_S, 1'b0});
    end
  endtask

  task automatic build_plan(input logic [1:0] p);
    plan.delete();
    if (p == 2'b00) begin
      plan.push_back('{1, FILL_S, 1'b1});
      add_cycles(WASH_CYC);
      plan.push_back('{6, DRAIN_S, 1'b1});
    end
    if (p != 2'b10) begin
      plan.push_back('{1, FILL_S, 1'b1});
      add_cycles(RINSE_CYC);
    end
    plan.push_back('{6, DRAIN_S, 1'b1});
    plan.push_back('{7, SPIN_S, 1'b0});
  endtask

  // Run a whole program. When boundary is set, every sensor arrives
  // together with the final tick of its step.
  task automatic run_plan(input logic [1:0] p, input bit boundary);
    int k;
    bit with_tick;
    build_plan(p);
    i_prog  = p;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("start_alarm_clr", o_alarm, 0);
    foreach (plan[i]) begin
      chk("step_phase", o_phase, plan[i].ph);
      chk("step_remain", o_remain, plan[i].dur);
      chk("step_act", act(), exp_act(plan[i].ph));
      chk("step_busy", o_busy, 1);
      chk("step_done", o_done, 0);
      if (plan[i].sens) begin
        if (plan[i].ph == 1) i_water_empty = 1'b0;
        else                 i_water_full  = 1'b0;
        k         = boundary ? plan[i].dur : $urandom_range(1, plan[i].dur);
        with_tick = boundary ? 1'b1 : 1'($urandom_range(0, 1));
        for (int t = 1; t < k; t++) begin
          do_tick();
          chk("sens_wait_remain", o_remain, plan[i].dur - t);
          chk("sens_wait_phase", o_phase, plan[i].ph);
        end
        if (plan[i].ph == 1) i_water_full  = 1'b1;  // stays high; ignored outside FILL
        else                 i_water_empty = 1'b1;
        i_tick = with_tick;
        step();
        i_tick        = 1'b0;
        i_water_empty = 1'b0;
        chk("sens_no_alarm", o_alarm, 0);
      end else begin
        for (int t = 1; t <= plan[i].dur; t++) begin
          do_tick();
          if (t < plan[i].dur) begin
            chk("timed_remain", o_remain, plan[i].dur - t);
            chk("timed_phase", o_phase, plan[i].ph);
          end
        end
      end
    end
    chk("end_phase", o_phase, 0);
    chk("end_done", o_done, 1);
    chk("end_busy", o_busy, 0);
    chk("end_alarm", o_alarm, 0);
    chk("end_act", act(), 0);
    chk("end_remain", o_remain, 0);
    step();
    chk("done_one_cycle", o_done, 0);
    i_water_full = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    i_tick        = 1'b0;
    i_start       = 1'b0;
    i_prog        = 2'b00;
    i_estop       = 1'b0;
    i_water_full  = 1'b0;
    i_water_empty = 1'b0;
    i_pause       = 1'b0;
    #1;
    chk("rst_phase", o_phase, 0);
    chk("rst_remain", o_remain, 0);
    chk("rst_act", act(), 0);
    chk("rst_flags", {o_busy, o_done, o_alarm}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Full program, sensors at the final tick of each FILL/DRAIN
    run_plan(2'b00, 1'b1);

    // Fill timeout
    i_prog  = 2'b00;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("to_fill", o_phase, 1);
    for (int t = 1; t <= 4; t++) begin
      do_tick();
      if (t < 4) chk("to_wait_phase", o_phase, 1);
    end
    chk("to_phase", o_phase, 0);
    chk("to_alarm", o_alarm, 1);
    chk("to_inlet", o_inlet, 0);
    chk("to_busy", o_busy, 0);
    chk("to_done", o_done, 0);
    i_estop = 1'b1;
    step();
    i_estop = 1'b0;
    chk("estop_keeps_alarm", o_alarm, 1);
    i_prog  = 2'b11;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("prog11_phase", o_phase, 0);
    chk("prog11_alarm", o_alarm, 1);

    // Spin-only; its start clears alarm
    run_plan(2'b10, 1'b0);

    // Start while busy, then estop mid AGIT_R
    i_prog  = 2'b00;
    i_start = 1'b1;
    step();
    i_start      = 1'b0;
    i_water_full = 1'b1;
    step();
    chk("es_agitf", o_phase, 2);
    i_prog  = 2'b10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_start_phase", o_phase, 2);
    chk("busy_start_remain", o_remain, AGIT_S);
    repeat (AGIT_S) do_tick();
    chk("es_resta", o_phase, 3);
    repeat (REST_S) do_tick();
    chk("es_agitr", o_phase, 4);
    do_tick();
    chk("es_rev_on", o_motor_rev, 1);
    i_estop = 1'b1;
    step();
    chk("es_rev_off", o_motor_rev, 0);
    chk("es_phase", o_phase, 0);
    chk("es_busy", o_busy, 0);
    chk("es_done", o_done, 0);
    chk("es_remain", o_remain, 0);
    i_prog  = 2'b00;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("es_start_ignored", o_phase, 0);
    step();
    chk("es_no_done", o_done, 0);
    i_estop      = 1'b0;
    i_water_full = 1'b0;

    // Asynchronous reset during SPIN
    i_prog  = 2'b10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("rs_drain", o_drain, 1);
    i_water_empty = 1'b1;
    step();
    i_water_empty = 1'b0;
    chk("rs_spin_phase", o_phase, 7);
    chk("rs_spin_act", act(), 5'b01001);
    do_tick();
    do_tick();
    chk("rs_spin_remain", o_remain, SPIN_S - 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_phase", o_phase, 0);
    chk("rs_async_act", act(), 0);
    chk("rs_async_remain", o_remain, 0);
    chk("rs_async_flags", {o_busy, o_done, o_alarm}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rs_no_done", o_done, 0);

`ifdef WASHER_PAUSE_EN
    // Pause in AGIT_F with two ticks left
    i_prog  = 2'b00;
    i_start = 1'b1;
    step();
    i_start      = 1'b0;
    i_water_full = 1'b1;
    step();
    do_tick();
    chk("pz_remain_pre", o_remain, 2);
    i_pause = 1'b1;
    step();
    chk("pz_fwd_off", o_motor_fwd, 0);
    for (int t = 0; t < 10; t++) begin
      do_tick();
      chk("pz_hold_remain", o_remain, 2);
      chk("pz_hold_phase", o_phase, 2);
      chk("pz_hold_fwd", o_motor_fwd, 0);
    end
    i_pause = 1'b0;
    step();
    chk("pz_fwd_back", o_motor_fwd, 1);
    chk("pz_remain_back", o_remain, 2);
    do_tick();
    chk("pz_remain_1", o_remain, 1);
    do_tick();
    chk("pz_resta", o_phase, 3);
    i_estop = 1'b1;
    step();
    i_estop      = 1'b0;
    i_water_full = 1'b0;
    step();
`endif

    // Randomized programs
    for (int r = 0; r < 4; r++) begin
      logic [1:0] p;
      p = 2'($urandom_range(0, 2));
      run_plan(p, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/washer_seq_ctrl.md
# washer_seq_ctrl

Program sequencer for the washing-machine datapath. It drives the water inlet valve, drain valve and the forward, reverse and spin motor enables through fill, agitate, drain and spin phases. Phase timing comes from a 1-second tick strobe, and water-level sensors close the fill and drain phases. It sits between the front-panel inputs (start, program select, emergency stop) and the actuator/LED drivers, replacing ad-hoc per-mode logic with one owned state machine.

## Interface
Parameters:
- FILL_S, 10: max ticks in FILL before a fault (1..127)
- AGIT_S, 60: ticks per forward or reverse agitation (1..127)
- REST_S, 5: ticks per pause between agitations (1..127)
- DRAIN_S, 20: max ticks in DRAIN before a fault (1..127)
- SPIN_S, 30: ticks in SPIN (1..127)
- WASH_CYC, 7: fwd/rev cycles in the wash stage (1..15)
- RINSE_CYC, 3: fwd/rev cycles in the rinse stage (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; **asynchronous, active-high**
- tick  in  1  one-cycle 1 Hz strobe
- start  in  1  one-cycle start request
- prog  in  2  program: 00 wash+rinse+spin, 01 rinse+spin, 10 spin only, 11 invalid
- estop  in  1  emergency stop, level
- water_full  in  1  level sensor high
- water_empty  in  1  level sensor low
- inlet, drain, motor_fwd, motor_rev, spin  out  1 each  actuator enables
- busy  out  1  program running
- done  out  1  one-cycle completion pulse
- alarm  out  1  latched fault flag
- phase  out  3  current state code
- remain  out  7  ticks left in the current timed step

## Operation
- **States and phase codes:** IDLE=0, FILL=1, AGIT_F=2, REST_A=3, AGIT_R=4, REST_B=5, DRAIN=6, SPIN=7.
- **Internal registers:**
  - stage: WASH or RINSE.
  - cyc: 4-bit cycle counter.
- **Start:**
  - start is accepted only in IDLE with prog≠11 and estop=0. Otherwise it is ignored.
  - Acceptance samples prog and clears alarm.
  - 00: stage=WASH, go to FILL.
  - 01: stage=RINSE, go to FILL.
  - 10: go to DRAIN, with SPIN following.
- **FILL (inlet=1):**
  - Exits to AGIT_F when water_full=1; cyc loads WASH_CYC or RINSE_CYC according to stage.
  - Timeout goes to IDLE with alarm=1.
- **Agitation loop:**
  - AGIT_F (motor_fwd=1) → REST_A → AGIT_R (motor_rev=1) → REST_B.
  - At the end of REST_B, cyc decrements. If the result is 0, go to DRAIN; otherwise go to AGIT_F.
- **DRAIN (drain=1):**
  - Exits when water_empty=1. The next state is:
    - FILL with stage=RINSE, if stage was WASH.
    - SPIN otherwise.
  - Timeout goes to IDLE with alarm=1.
- **SPIN (drain=1, spin=1):** runs SPIN_S ticks, then goes to IDLE with done=1 for one cycle.
- **Output decode:**
  - Actuators are decoded from the state register; only the listed signals are 1 in each state.
  - busy = (state≠IDLE).
  - motor_fwd and motor_rev are never both 1.
- **Timer:**
  - remain loads the step duration on every state entry and decrements on tick.
  - A tick with remain==1 ends a timed step, or raises the fault for FILL and DRAIN. Each step therefore lasts exactly N ticks.
  - In IDLE, remain is 0.
- **estop=1 (any state):** next edge goes to IDLE. Actuators are off, done is not pulsed, alarm is unchanged, and cyc/stage are cleared.
- **Priority, highest first:** rst > estop > sensor exit > tick timeout.
  - water_full (in FILL) or water_empty (in DRAIN) arriving with the final tick counts as a normal exit.
  - Sensors are ignored outside FILL and DRAIN.

## Timing
- Reset (async assert): state=IDLE. All outputs are 0, including alarm, phase and remain. cyc=0, stage=WASH.
- Reset mid-program aborts immediately with no done pulse.
- start → phase/actuators change on the next rising edge (1-cycle latency).
- A sensor exit or final tick changes the state at the same edge it is sampled.
- done is asserted in the first IDLE cycle after SPIN and lasts exactly 1 cycle.
- estop → actuators deasserted one edge after estop is sampled high.

## Configuration
- **WASHER_PAUSE_EN** defined:
  - Adds input `pause` (1 bit, level).
  - While pause=1 in any non-IDLE state: state, remain and cyc hold, tick is ignored, and all actuators are forced to 0.
  - estop and rst still act during pause.
  - On release, the step resumes with the remaining count.
- **WASHER_PAUSE_EN** undefined: no pause port; behaviour as above.

## Test plan
Common parameters: FILL_S=4, AGIT_S=3, REST_S=2, DRAIN_S=4, SPIN_S=5, WASH_CYC=2, RINSE_CYC=1.

- **Full program:** prog=00, start, water_full after 2 ticks in each FILL, water_empty after 1 tick in each DRAIN.
  - Phase sequence 1,2,3,4,5,2,3,4,5,6,1,2,3,4,5,6,7,0.
  - Each AGIT lasts 3 ticks, each REST 2, SPIN 5.
  - done is pulsed once, alarm=0.
- **Fill timeout:** prog=00, water_full held 0.
  - After 4 ticks in FILL: phase=0, alarm=1, inlet=0, busy=0, done=0.
  - A next valid start clears alarm.
- **Emergency stop:** estop=1 mid-AGIT_R.
  - Next edge: motor_rev=0, phase=0, busy=0, no done.
  - start while estop=1 is ignored.
- **Spin-only:** prog=10.
  - DRAIN until water_empty, then SPIN with drain=spin=1 for 5 ticks, then done.
  - prog=11 start: no state change.
- **Boundary:** water_full with the 4th FILL tick gives AGIT_F, no alarm.
  - rst pulse during SPIN gives all outputs 0 asynchronously.
  - start while busy is ignored.
- **Pause (WASHER_PAUSE_EN defined):** pause=1 for 10 ticks in AGIT_F with remain=2.
  - motor_fwd=0 and remain stays 2 throughout.
  - After release, 2 more ticks, then REST_A.
